// File: rtl/seg7_pkg.sv
// seg7_pkg: segment indices, active-low hex patterns and digit selects for the multiplexed 7-seg display
package seg7_pkg;
    localparam int SEG_A  = 0;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;
    localparam logic [6:0] BLANK = 7'h7F;
    localparam logic [15:0][6:0] HEX_PAT = '{
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };
    localparam logic [3:0] DIG_UNITS     = 4'b1110;
    localparam logic [3:0] DIG_TENS      = 4'b1101;
    localparam logic [3:0] DIG_HUNDREDS  = 4'b1011;
    localparam logic [3:0] DIG_THOUSANDS = 4'b0111;
endpackage

// File: rtl/seg_to_hex.sv
// seg_to_hex: reverse-decodes an active-low gfedcba pattern to a hex nibble
module seg_to_hex
    import seg7_pkg::*;
(
    input  logic [6:0] pat,
    output logic [3:0] nib,
    output logic       ok
);
    always_comb begin
        nib = '0;
        ok  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (pat == HEX_PAT[i]) begin
                nib = 4'(i);
                ok  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/capture_7_seg.sv
// capture_7_seg: samples scanned SEG/DIGIT pins, debounces each digit strobe,
// decodes it and publishes complete four-digit frames.
module capture_7_seg
    import seg7_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] SEG,
    input  logic [3:0] DIGIT,
    output logic [3:0] units,
    output logic [3:0] tens,
    output logic [3:0] hundreds,
    output logic [3:0] thousands,
    output logic [3:0] DP,
    output logic       FRAME_VALID,
    output logic       DECODE_ERR,
    output logic       STALE
);
    localparam logic [7:0]  SETTLE_MAX = 8'(SETTLE_CYCLES);
    localparam logic [7:0]  SETTLE_ACC = 8'(SETTLE_CYCLES - 1);
    localparam logic [23:0] TMO        = 24'(TIMEOUT_CYCLES);
    logic [7:0]       seg_m, seg_s, seg_p;
    logic [3:0]       dig_m, dig_s, dig_p;
    logic [7:0]       stab;
    logic [23:0]      tcnt;
    logic [3:0][3:0]  stage;
    logic [3:0]       stage_dp, seen, seen_base;
    logic             err_p, err_base;
    logic [1:0]       sel;
    logic [3:0]       nib;
    logic             hex_ok, dig_ok, vacc, pub, tmo_hit;

    seg_to_hex u_dec (.pat(seg_p[SEG_G:SEG_A]), .nib(nib), .ok(hex_ok));

    always_comb begin
        sel       = dig_p == DIG_UNITS ? 2'd0 : dig_p == DIG_TENS ? 2'd1 :
                    dig_p == DIG_HUNDREDS ? 2'd2 : 2'd3;
        dig_ok    = dig_p inside {DIG_UNITS, DIG_TENS, DIG_HUNDREDS, DIG_THOUSANDS};
        vacc      = stab == SETTLE_ACC && dig_ok;
        pub       = seen == 4'hF;
        tmo_hit   = !vacc && tcnt == TMO - 24'd1;
        seen_base = pub ? 4'h0 : seen;
        err_base  = pub ? 1'b0 : err_p;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            seg_m       <= {1'b1, BLANK};
            seg_s       <= {1'b1, BLANK};
            seg_p       <= {1'b1, BLANK};
            dig_m       <= '1;
            dig_s       <= '1;
            dig_p       <= '1;
            stab        <= '0;
            tcnt        <= '0;
            stage       <= '0;
            stage_dp    <= '0;
            seen        <= '0;
            err_p       <= 1'b0;
            {thousands, hundreds, tens, units} <= '0;
            DP          <= '0;
            FRAME_VALID <= 1'b0;
            DECODE_ERR  <= 1'b0;
            STALE       <= 1'b0;
        end else begin
            seg_m       <= SEG;
            seg_s       <= seg_m;
            seg_p       <= seg_s;
            dig_m       <= DIGIT;
            dig_s       <= dig_m;
            dig_p       <= dig_s;
            stab        <= {seg_s, dig_s} != {seg_p, dig_p} ? 8'd0 :
                           stab == SETTLE_MAX ? stab : stab + 8'd1;
            FRAME_VALID <= pub;
            if (pub) begin
                {thousands, hundreds, tens, units} <= stage;
                DP         <= stage_dp;
                DECODE_ERR <= err_p;
            end
            // A valid accept beats a timeout landing in the same cycle
            if (vacc) begin
                stage[sel]    <= hex_ok ? nib : 4'd0;
                stage_dp[sel] <= ~seg_p[SEG_DP];
                tcnt          <= '0;
                STALE         <= 1'b0;
            end else if (tcnt != TMO) begin
                tcnt <= tcnt + 24'd1;
                if (tmo_hit) STALE <= 1'b1;
            end
            seen  <= vacc ? seen_base | (4'b1 << sel) : tmo_hit ? 4'h0 : seen_base;
            err_p <= vacc ? err_base | ~hex_ok : tmo_hit ? 1'b0 : err_base;
        end
    end
endmodule

// File: tb/tb_capture_7_seg.sv
// tb_capture_7_seg: directed scan frames; expected frames queued, checked by a FRAME_VALID monitor
module tb_capture_7_seg;
    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [7:0] SEG = 8'hFF;
    logic [3:0] DIGIT = 4'hF;
    logic [3:0] units, tens, hundreds, thousands, DP;
    logic       FRAME_VALID, DECODE_ERR, STALE;

    capture_7_seg #(.SETTLE_CYCLES(16), .TIMEOUT_CYCLES(1000)) dut (
        .CLK(CLK), .RST_N(RST_N), .SEG(SEG), .DIGIT(DIGIT),
        .units(units), .tens(tens), .hundreds(hundreds), .thousands(thousands),
        .DP(DP), .FRAME_VALID(FRAME_VALID), .DECODE_ERR(DECODE_ERR), .STALE(STALE)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [3:0] th, hu, te, un, dp;
        logic       err;
    } frm_t;

    localparam logic [3:0] UN = 4'b1110, TE = 4'b1101, HU = 4'b1011, TH = 4'b0111;
    logic [6:0] pat [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    frm_t q[$];
    frm_t exp_f, act_f;
    int checks = 0, passes = 0;
    logic fv_d = 1'b0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a === e) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    endtask

    task automatic show(input logic [3:0] d, input logic [6:0] p, input logic dp, input int n);
        @(negedge CLK);
        DIGIT = d;
        SEG   = {~dp, p};
        repeat (n - 1) @(negedge CLK);
    endtask

    task automatic push(input logic [3:0] th, hu, te, un, dp, input logic err);
        q.push_back('{th: th, hu: hu, te: te, un: un, dp: dp, err: err});
    endtask

    task automatic chk_outs_zero();
        chk("rst_units", 32'(units), 0);
        chk("rst_tens", 32'(tens), 0);
        chk("rst_hundreds", 32'(hundreds), 0);
        chk("rst_thousands", 32'(thousands), 0);
        chk("rst_dp", 32'(DP), 0);
        chk("rst_frame_valid", 32'(FRAME_VALID), 0);
        chk("rst_decode_err", 32'(DECODE_ERR), 0);
        chk("rst_stale", 32'(STALE), 0);
    endtask

    always @(negedge CLK) begin
        if (RST_N && FRAME_VALID) begin
            if (fv_d) chk("frame_valid_back_to_back", 32'(fv_d), 0);
            if (q.size() == 0) chk("unexpected_frame", 32'(FRAME_VALID), 0);
            else begin
                exp_f = q.pop_front();
                act_f = '{th: thousands, hu: hundreds, te: tens, un: units, dp: DP, err: DECODE_ERR};
                chk("frame", 32'(act_f), 32'(exp_f));
            end
        end
        fv_d = FRAME_VALID && RST_N;
    end

    initial begin
        repeat (3) @(negedge CLK);
        chk_outs_zero();
        RST_N = 1'b1;
        // clean frame 4,3,2,1
        show(TH, pat[4], 0, 100);
        show(HU, pat[3], 0, 100);
        show(TE, pat[2], 0, 100);
        push(4, 3, 2, 1, 4'b0000, 0);
        show(UN, pat[1], 0, 100);
        // tens dp, invalid two-low DIGIT mid-frame, blank units
        show(TH, pat[5], 0, 100);
        show(HU, pat[6], 0, 100);
        show(TE, pat[7], 1, 100);
        show(4'b1100, pat[8], 0, 100);
        push(5, 6, 7, 0, 4'b0010, 1);
        show(UN, 7'h7F, 0, 100);
        // short glitch of all-segments-on during held units digit
        show(UN, pat[1], 0, 40);
        show(UN, 7'h00, 1, 5);
        show(UN, pat[1], 0, 60);
        show(TE, pat[10], 0, 100);
        show(HU, pat[9], 0, 100);
        push(8, 9, 4'hA, 1, 4'b0000, 0);
        show(TH, pat[8], 0, 100);
        // three digits then silence until stale
        show(TH, pat[1], 0, 100);
        show(HU, pat[2], 0, 100);
        show(TE, pat[3], 0, 100);
        show(4'b1100, pat[8], 0, 800);
        chk("stale_before_timeout", 32'(STALE), 0);
        repeat (200) @(negedge CLK);
        chk("stale_after_timeout", 32'(STALE), 1);
        show(TH, pat[4], 0, 40);
        chk("stale_cleared_by_accept", 32'(STALE), 0);
        repeat (60) @(negedge CLK);
        show(HU, pat[5], 0, 100);
        show(TE, pat[6], 0, 100);
        push(4, 5, 6, 7, 4'b0000, 0);
        show(UN, pat[7], 0, 100);
        // reset after two accepted digits
        show(TH, pat[9], 0, 100);
        show(HU, pat[8], 0, 100);
        @(negedge CLK);
        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        chk_outs_zero();
        RST_N = 1'b1;
        show(TH, pat[2], 1, 100);
        show(HU, pat[0], 0, 100);
        show(TE, pat[15], 0, 100);
        push(2, 0, 4'hF, 4'hE, 4'b1000, 0);
        show(UN, pat[14], 0, 100);
        repeat (20) @(negedge CLK);
        chk("frames_outstanding", 32'(q.size()), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
